// File: rtl/dbg_prog_loader.sv
// ---------------------------------------------------------------------------
// dbg_prog_loader
//
// Streams a program image into the core's instruction memory through the
// debug write port while holding the core in reset, then releases the core
// RST_HOLD cycles after the final write.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active-low
//   start        one-cycle pulse; begins a new load (honoured in IDLE/RUN/ERROR)
//   start_addr   byte address of the first word (low alignment bits ignored)
//   s_valid      input word valid
//   s_ready      loader accepts a word this cycle
//   s_data       instruction word
//   s_last       final word of the image
//   dbg_wr_en    imem write strobe
//   dbg_addr     imem byte address (held while dbg_wr_en=0)
//   dbg_instr    imem write data   (held while dbg_wr_en=0)
//   core_rst     active-high reset to the core
//   busy         high in LOAD and HOLD
//   done         high in RUN
//   err          overflow flag; stays set until the next accepted start
//   word_cnt     words written in the current or last load
//   dbg_state    FSM state: 0 IDLE, 1 LOAD, 2 HOLD, 3 RUN, 4 ERROR
//
// Handshake: a word transfers on every rising edge where s_valid && s_ready.
// s_ready is a pure function of state (high only in LOAD) and never depends
// on s_valid. The producer holds s_data/s_last stable while s_valid is high
// and s_ready is low. Each transferred word appears on the debug write port
// exactly one cycle later.
// ---------------------------------------------------------------------------
module dbg_prog_loader #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 256,
  parameter int RST_HOLD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [XLEN-1:0]            start_addr,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [XLEN-1:0]            s_data,
  input  logic                       s_last,
  output logic                       dbg_wr_en,
  output logic [XLEN-1:0]            dbg_addr,
  output logic [XLEN-1:0]            dbg_instr,
  output logic                       core_rst,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] word_cnt,
  output logic [2:0]                 dbg_state
);

  localparam int CW     = $clog2(DEPTH + 1);
  localparam int HW     = $clog2(RST_HOLD + 1);
  localparam int STRIDE = XLEN / 8;
  // Clears the byte-offset bits so every write is word aligned.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(STRIDE) - XLEN'(1));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] ptr;
  logic [HW-1:0]   hold_cnt;

  logic hs;         // word transferred this cycle
  logic start_ok;   // start honoured this cycle
  logic last_slot;  // the next accepted word fills the final DEPTH slot
  logic hold_done;  // final HOLD cycle

  assign hs        = (state == S_LOAD) && s_valid;
  assign start_ok  = start && ((state == S_IDLE) || (state == S_RUN) || (state == S_ERROR));
  assign last_slot = (word_cnt == CW'(DEPTH - 1));
  assign hold_done = (hold_cnt == HW'(RST_HOLD - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // s_last wins over overflow: a DEPTH-th word carrying s_last is legal.
        if (hs) begin
          if (s_last)         state_nxt = S_HOLD;
          else if (last_slot) state_nxt = S_ERROR;
        end
      end
      S_HOLD: begin
        if (hold_done) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs. core_rst follows state, so it rises on the same
  // edge that accepts start and falls on the edge that leaves HOLD.
  always_comb begin
    s_ready   = (state == S_LOAD);
    busy      = (state == S_LOAD) || (state == S_HOLD);
    done      = (state == S_RUN);
    err       = (state == S_ERROR);
    core_rst  = (state != S_RUN);
    dbg_state = state;
  end

  // Datapath: write pointer, word counter, registered write port, hold timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      word_cnt  <= '0;
      hold_cnt  <= '0;
      dbg_wr_en <= 1'b0;
      dbg_addr  <= '0;
      dbg_instr <= '0;
    end else begin
      dbg_wr_en <= hs;
      if (start_ok) begin
        ptr      <= start_addr & ALIGN_MASK;
        word_cnt <= '0;
      end else if (hs) begin
        dbg_addr  <= ptr;
        dbg_instr <= s_data;
        ptr       <= ptr + XLEN'(STRIDE);   // wraps modulo 2^XLEN
        word_cnt  <= word_cnt + CW'(1);
      end
      if (state == S_HOLD) hold_cnt <= hold_cnt + HW'(1);
      else                 hold_cnt <= '0;
    end
  end

endmodule
